// File: rtl/q8_8_divider_pkg.sv
// -----------------------------------------------------------------------------
// q8_8_divider_pkg
// Shared constants and types for the signed Q8.8 fixed-point divider.
//   Q_WIDTH     : total operand/result width in bits
//   Q_FRAC      : fractional bits of the fixed-point format
//   div_state_t : divider control states (IDLE -> CALC -> DONE)
// -----------------------------------------------------------------------------
package q8_8_divider_pkg;

    localparam int Q_WIDTH = 16;
    localparam int Q_FRAC  = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/q8_8_divider.sv
// -----------------------------------------------------------------------------
// q8_8_divider
// Sequential signed fixed-point divider (Q8.8 by default). Restoring division,
// one quotient bit per CALC cycle, MSB first, WIDTH+FRAC cycles per result.
// Quotient is truncated toward zero; ovf flags results outside the signed
// WIDTH-bit range; div_zero flags a zero divisor (resolved without iterating).
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1. in_ready is 1 only in IDLE, out_valid only in DONE; results are held
// stable in DONE until out_ready. Operand inputs are ignored outside IDLE.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   in_valid  in   dividend/divisor pair offered
//   in_ready  out  pair accepted this cycle (IDLE)
//   dividend  in   signed Q8.8 numerator
//   divisor   in   signed Q8.8 denominator
//   out_valid out  quotient and flags valid (DONE)
//   out_ready in   consumer takes the result this cycle
//   quotient  out  signed Q8.8 result
//   ovf       out  true quotient outside representable range
//   div_zero  out  divisor was zero
//   state     out  current control state (debug)
//
// Configuration macro: Q8_8_DIV_SATURATE_EN
//   defined   : overflow and divide-by-zero produce saturated quotients
//   undefined : overflow wraps to the low WIDTH bits, divide-by-zero gives 0
// -----------------------------------------------------------------------------
module q8_8_divider
    import q8_8_divider_pkg::*;
#(
    parameter int WIDTH = Q_WIDTH,
    parameter int FRAC  = Q_FRAC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic             ovf,
    output logic             div_zero,
    output div_state_t       state
);

    localparam int NW = WIDTH + FRAC;   // numerator / raw quotient width
    localparam int CW = $clog2(NW);     // iteration counter width
    localparam logic [NW-1:0] POS_LIM = NW'((64'd1 << (WIDTH-1)) - 64'd1);
    localparam logic [NW-1:0] NEG_LIM = NW'(64'd1 << (WIDTH-1));

    div_state_t        state_r, next_state;
    logic              sign_r;
    logic [WIDTH-1:0]  dvs_mag_r;
    logic [WIDTH-1:0]  rem_r;
    logic [NW-1:0]     num_r;          // numerator shifts out, quotient bits shift in
    logic [CW-1:0]     cnt_r;

    logic [WIDTH-1:0]  dvd_mag, dvs_mag;
    logic [WIDTH:0]    trial;
    logic              take;
    logic [WIDTH-1:0]  rem_nx;
    logic [NW-1:0]     num_nx;
    logic              dvs_zero, last;
    logic              ovf_nx;
    logic [WIDTH-1:0]  signed_low;
    logic [WIDTH-1:0]  q_res;
    logic [WIDTH-1:0]  dz_q;

    assign state = state_r;

    // Magnitudes as unsigned WIDTH-bit values; the most negative input maps
    // to 1 << (WIDTH-1), which still fits unsigned.
    assign dvd_mag = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
    assign dvs_mag = divisor[WIDTH-1]  ? (~divisor  + WIDTH'(1)) : divisor;

    // One restoring step. The partial remainder is always below the divisor,
    // so after subtraction it fits back into WIDTH bits.
    assign trial  = {rem_r, num_r[NW-1]};
    assign take   = (trial >= {1'b0, dvs_mag_r});
    assign rem_nx = take ? (trial[WIDTH-1:0] - dvs_mag_r) : trial[WIDTH-1:0];
    assign num_nx = {num_r[NW-2:0], take};

    assign dvs_zero = (dvs_mag_r == '0);
    assign last     = (cnt_r == CW'(NW - 1));

    // Final result is formed from the last step's shifted value so it can be
    // registered on the same edge that enters DONE.
    assign ovf_nx     = sign_r ? (num_nx > NEG_LIM) : (num_nx > POS_LIM);
    assign signed_low = sign_r ? (~num_nx[WIDTH-1:0] + WIDTH'(1)) : num_nx[WIDTH-1:0];

`ifdef Q8_8_DIV_SATURATE_EN
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    logic dvd_neg_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_neg_r <= 1'b0;
        end else if (state_r == S_IDLE && in_valid) begin
            dvd_neg_r <= dividend[WIDTH-1];
        end
    end

    assign q_res = ovf_nx ? (sign_r ? MIN_NEG : MAX_POS) : signed_low;
    assign dz_q  = dvd_neg_r ? MIN_NEG : MAX_POS;
`else
    assign q_res = signed_low;
    assign dz_q  = '0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        next_state = state_r;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_r)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = S_CALC;
            end
            S_CALC: begin
                if (dvs_zero || last) next_state = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_r    <= 1'b0;
            dvs_mag_r <= '0;
            rem_r     <= '0;
            num_r     <= '0;
            cnt_r     <= '0;
            quotient  <= '0;
            ovf       <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        sign_r    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        dvs_mag_r <= dvs_mag;
                        rem_r     <= '0;
                        num_r     <= {dvd_mag, {FRAC{1'b0}}};
                        cnt_r     <= '0;
                    end
                end
                S_CALC: begin
                    if (dvs_zero) begin
                        // Zero divisor: no iterations, result decided at once.
                        quotient <= dz_q;
                        ovf      <= 1'b0;
                        div_zero <= 1'b1;
                    end else begin
                        rem_r <= rem_nx;
                        num_r <= num_nx;
                        cnt_r <= cnt_r + CW'(1);
                        if (last) begin
                            quotient <= q_res;
                            ovf      <= ovf_nx;
                            div_zero <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_q8_8_divider.sv
// -----------------------------------------------------------------------------
// tb_q8_8_divider
// Self-checking bench for q8_8_divider. Driver tasks push expected results
// into a queue on acceptance; a monitor pops and compares on each new result.
// -----------------------------------------------------------------------------
module tb_q8_8_divider;
    import q8_8_divider_pkg::*;

`ifdef Q8_8_DIV_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic        ovf;
    logic        div_zero;
    div_state_t  state;

    logic        man_ready;
    logic        rand_ready;
    logic        rnd_ready;

    always #5 clk = ~clk;

    assign out_ready = rand_ready ? rnd_ready : man_ready;

    q8_8_divider dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .ovf       (ovf),
        .div_zero  (div_zero),
        .state     (state)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial rnd_ready = 1'b1;
    always @(posedge clk) begin
        #1 rnd_ready = ($urandom_range(0, 3) != 0);
    end

    // ---------------- scoreboard ----------------
    // entry: {latency[7:0], div_zero, ovf, quotient[15:0]}
    logic [25:0] exp_q[$];
    int          acc_q[$];
    bit          seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [25:0] e;
        int          a;
        if (rst || !out_valid) begin
            seen = 1'b0;
        end else if (!seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: out_valid with no pending op, quotient %h", quotient);
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                chk("quotient", 32'(quotient), 32'(e[15:0]));
                chk("ovf", 32'(ovf), 32'(e[16]));
                chk("div_zero", 32'(div_zero), 32'(e[17]));
                chk("latency", 32'(cyc - a), 32'(e[25:18]));
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [17:0] ref_div(input logic [15:0] a, input logic [15:0] b);
        longint      n, d, q;
        logic [15:0] qo;
        bit          o;
        if (b == 16'h0000)
            return {1'b1, 1'b0, SAT ? (a[15] ? 16'h8000 : 16'h7FFF) : 16'h0000};
        n  = longint'($signed(a)) * 256;
        d  = longint'($signed(b));
        q  = n / d;
        o  = (q > 32767) || (q < -32768);
        qo = q[15:0];
        if (SAT && o) qo = (q > 0) ? 16'h7FFF : 16'h8000;
        return {1'b0, o, qo};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input bit eo, input bit ed,
                         input int lat, input bit track);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL in_ready_timeout: in_ready %b expected 1", in_ready);
            return;
        end
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (track) begin
            exp_q.push_back({lat[7:0], ed, eo, eq});
            acc_q.push_back(cyc);
        end
        @(negedge clk);
        in_valid = 1'b0;
        // junk on the operand bus while busy must be ignored
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d results pending expected 0", exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_quotient"},  32'(quotient),  32'd0);
        chk({tag, "_ovf"},       32'(ovf),       32'd0);
        chk({tag, "_div_zero"},  32'(div_zero),  32'd0);
        chk({tag, "_state"},     32'(state),     32'(S_IDLE));
    endtask

    // ---------------- directed vectors ----------------
    localparam int ND = 13;
    logic [15:0] d_a  [ND] = '{16'h0300, 16'hFF00, 16'h8000, 16'h0100, 16'hFF00, 16'h0000, 16'h8000,
                               16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000, 16'h0080, 16'hFF80};
    logic [15:0] d_b  [ND] = '{16'h0200, 16'h0400, 16'hFF00, 16'h0000, 16'h0000, 16'h0000, 16'h0100,
                               16'h0100, 16'h0001, 16'h0001, 16'hFF00, 16'h0300, 16'h0300};
    logic [15:0] d_qs [ND] = '{16'h0180, 16'hFFC0, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000,
                               16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000, 16'h002A, 16'hFFD6};
    logic [15:0] d_qn [ND] = '{16'h0180, 16'hFFC0, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h8000,
                               16'h7FFF, 16'h0000, 16'hFF00, 16'h0000, 16'h002A, 16'hFFD6};
    bit          d_o  [ND] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    bit          d_z  [ND] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};

    // ---------------- main sequence ----------------
    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        dividend   = '0;
        divisor    = '0;
        man_ready  = 1'b1;
        rand_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        for (int i = 0; i < ND; i++) begin
            do_op(d_a[i], d_b[i], SAT ? d_qs[i] : d_qn[i], d_o[i], d_z[i],
                  d_z[i] ? 1 : 24, 1'b1);
        end
        drain();

        // Back-pressure: result held for 10 cycles, then released.
        begin
            int n = 0;
            man_ready = 1'b0;
            do_op(16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 24, 1'b1);
            while (!out_valid && n < 60) begin
                @(negedge clk);
                n++;
            end
            chk("stall_reached_done", 32'(out_valid), 32'd1);
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                chk("stall_quotient",  32'(quotient),  32'h0180);
                chk("stall_ovf",       32'(ovf),       32'd0);
                chk("stall_div_zero",  32'(div_zero),  32'd0);
                chk("stall_out_valid", 32'(out_valid), 32'd1);
                chk("stall_in_ready",  32'(in_ready),  32'd0);
            end
            man_ready = 1'b1;
            @(negedge clk);
            chk("release_out_valid", 32'(out_valid), 32'd0);
            chk("release_in_ready",  32'(in_ready),  32'd1);
            drain();
        end

        // Reset during CALC: operation discarded, outputs to reset values at once.
        do_op(16'h0300, 16'h0100, 16'h0000, 1'b0, 1'b0, 24, 1'b0);
        repeat (11) @(posedge clk);
        #2;
        chk("mid_calc_state", 32'(state), 32'(S_CALC));
        rst = 1'b1;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        do_op(16'h0100, 16'h0100, 16'h0100, 1'b0, 1'b0, 24, 1'b1);
        drain();

        // Random pairs against the reference model, random back-pressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] a, b;
            logic [17:0] r;
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       b = 16'($urandom_range(0, 16'h01FF));
                1:       b = 16'hFFFF - 16'($urandom_range(0, 16'h01FF));
                default: b = 16'($urandom);
            endcase
            r = ref_div(a, b);
            do_op(a, b, r[15:0], r[16], r[17], r[17] ? 1 : 24, 1'b1);
        end
        drain();
        rand_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, %0d results pending", exp_q.size());
        $fatal(1, "watchdog");
    end

endmodule
